mem_access_stage: RTL and testbench

- Pipeline MEM stage. Consumes the EX/MEM register, performs loads and stores against a variable-latency data memory through a req/ack handshake, and produces the registered MEM/WB register (pipe_MEM_WB_reg_t) for the write-back stage.
- Stalls upstream stages while a memory access is outstanding.
- Handles byte/half/word sizing and sign extension.

---
 rtl/mem_access_stage_pkg.sv | 59 +++++
 rtl/mem_access_stage_load_extract.sv | 28 ++
 rtl/mem_access_stage.sv | 145 ++++++++++++++
 tb/tb_mem_access_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM pipeline stage: pipeline register layouts,
// access sizes, FSM states and byte-enable patterns.
package mem_access_stage_pkg;

    localparam int XLEN     = 32;
    localparam int REG_ID_W = 5;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef struct packed {
        logic      mem_read;
        logic      mem_write;
        logic      reg_write;
        logic      mem_to_reg;
        mem_size_t mem_size;
        logic      mem_signed;
    } mem_ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]     inst;
        mem_ctrl_t           signals;
        logic [XLEN-1:0]     alu_result;
        logic [XLEN-1:0]     store_data;
        logic [REG_ID_W-1:0] write_id;
    } pipe_EX_MEM_reg_t;

    typedef struct packed {
        logic [XLEN-1:0]     inst;
        mem_ctrl_t           signals;
        logic [XLEN-1:0]     result;
        logic [REG_ID_W-1:0] write_id;
    } pipe_MEM_WB_reg_t;

    // Half accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic addr_misaligned(input mem_size_t size, input logic [1:0] a);
        logic bad;
        case (size)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = a[0];
            default: bad = |a;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_extract.sv
// Load data alignment: picks the addressed byte/half out of the memory word
// and zero- or sign-extends it to 32 bits. Purely combinational.
module load_extract
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]      a,
    input  mem_size_t       size,
    input  logic            mem_signed,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        byte_sel = rdata[{a, 3'b000} +: 8];
        half_sel = a[1] ? rdata[31:16] : rdata[15:0];
        result   = rdata;
        case (size)
            MEM_B:   result = {{24{mem_signed & byte_sel[7]}}, byte_sel};
            MEM_H:   result = {{16{mem_signed & half_sel[15]}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: req/ack data-memory access, store lane steering, load
// extraction, registered MEM/WB output. Optional trap: MEM_MISALIGN_TRAP_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  pipe_EX_MEM_reg_t  ex_mem_in,
    input  logic              ex_mem_valid,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output pipe_MEM_WB_reg_t  mem_wb_out,
    output logic              mem_wb_valid,
    output logic              misalign
);

    mem_ctrl_t        sig;
    logic [1:0]       a;
    logic             memop;
    logic             misalign_hit;
    logic             access_op;
    logic             ack_seen;
    logic [XLEN-1:0]  load_data;
    pipe_MEM_WB_reg_t wb_pass;

    mem_state_t       state_q,        state_d;
    pipe_MEM_WB_reg_t mem_wb_q,       mem_wb_d;
    logic             mem_wb_valid_q, mem_wb_valid_d;
    logic             misalign_q,     misalign_d;

    assign sig   = ex_mem_in.signals;
    assign a     = ex_mem_in.alu_result[1:0];
    assign memop = ex_mem_valid & (sig.mem_read | sig.mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_hit = memop & addr_misaligned(sig.mem_size, a);
`else
    assign misalign_hit = 1'b0;
`endif

    // A trapped access behaves like a non-memop: no request, no stall.
    assign access_op = memop & ~misalign_hit;
    assign ack_seen  = (state_q == ACCESS) & dmem_ack;
    assign mem_stall = access_op & ~ack_seen;

    // Request is purely a function of state so an async reset drops it at once.
    assign dmem_req  = (state_q == ACCESS);
    assign dmem_we   = sig.mem_write;
    assign dmem_addr = {ex_mem_in.alu_result[ADDR_W-1:2], 2'b00};

    always_comb begin
        dmem_be    = BE_WORD;
        dmem_wdata = ex_mem_in.store_data;
        case (sig.mem_size)
            MEM_B: begin
                dmem_be    = BE_BYTE << a;
                dmem_wdata = {4{ex_mem_in.store_data[7:0]}};
            end
            MEM_H: begin
                dmem_be    = a[1] ? BE_HALF_HI : BE_HALF_LO;
                dmem_wdata = {2{ex_mem_in.store_data[15:0]}};
            end
            default: begin
                dmem_be    = BE_WORD;
                dmem_wdata = ex_mem_in.store_data;
            end
        endcase
    end

    load_extract u_load_extract (
        .a          (a),
        .size       (sig.mem_size),
        .mem_signed (sig.mem_signed),
        .rdata      (dmem_rdata),
        .result     (load_data)
    );

    always_comb begin
        wb_pass.inst     = ex_mem_in.inst;
        wb_pass.signals  = sig;
        wb_pass.result   = ex_mem_in.alu_result;
        wb_pass.write_id = ex_mem_in.write_id;
    end

    always_comb begin
        state_d        = state_q;
        mem_wb_d       = mem_wb_q;
        mem_wb_valid_d = 1'b0;
        misalign_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_op) begin
                    state_d = ACCESS;
                end else begin
                    mem_wb_d       = wb_pass;
                    mem_wb_valid_d = ex_mem_valid;
                    if (misalign_hit) begin
                        mem_wb_d.signals.reg_write = 1'b0;
                        misalign_d                 = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    mem_wb_d = wb_pass;
                    if (sig.mem_read && sig.mem_to_reg) begin
                        mem_wb_d.result = load_data;
                    end
                    mem_wb_valid_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            mem_wb_q       <= '0;
            mem_wb_valid_q <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_wb_q       <= mem_wb_d;
            mem_wb_valid_q <= mem_wb_valid_d;
            misalign_q     <= misalign_d;
        end
    end

    assign mem_wb_out   = mem_wb_q;
    assign mem_wb_valid = mem_wb_valid_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: scoreboard of expected MEM/WB
// records, per-op checks of request lanes, stall length and latency.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    pipe_EX_MEM_reg_t ex_mem_in = '0;
    logic             ex_mem_valid = 1'b0;
    logic             mem_stall;
    logic             dmem_req;
    logic             dmem_we;
    logic [31:0]      dmem_addr;
    logic [3:0]       dmem_be;
    logic [31:0]      dmem_wdata;
    logic [31:0]      dmem_rdata = '0;
    logic             dmem_ack = 1'b0;
    pipe_MEM_WB_reg_t mem_wb_out;
    logic             mem_wb_valid;
    logic             misalign;

    mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .ex_mem_in    (ex_mem_in),
        .ex_mem_valid (ex_mem_valid),
        .mem_stall    (mem_stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .mem_wb_out   (mem_wb_out),
        .mem_wb_valid (mem_wb_valid),
        .misalign     (misalign)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        pipe_MEM_WB_reg_t wb;
        logic             misalign;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Independent reference: an access covers bytes [start, start+len).
    function automatic int lane_len(input mem_size_t size);
        case (size)
            MEM_B:   return 1;
            MEM_H:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int lane_start(input mem_size_t size, input logic [31:0] addr);
        int len = lane_len(size);
        return (int'(addr[1:0]) / len) * len;
    endfunction

    function automatic logic trap_expected(input pipe_EX_MEM_reg_t op);
        int  len = lane_len(op.signals.mem_size);
        logic m  = (int'(op.alu_result[1:0]) % len) != 0;
        return TRAP_EN & (op.signals.mem_read | op.signals.mem_write) & m;
    endfunction

    function automatic logic [3:0] exp_be(input pipe_EX_MEM_reg_t op);
        int s = lane_start(op.signals.mem_size, op.alu_result);
        int l = lane_len(op.signals.mem_size);
        logic [3:0] be = '0;
        for (int i = 0; i < 4; i++) be[i] = (i >= s) && (i < s + l);
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input pipe_EX_MEM_reg_t op);
        int l = lane_len(op.signals.mem_size);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = op.store_data[8*(i % l) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input pipe_EX_MEM_reg_t op, input logic [31:0] rdata);
        int s = lane_start(op.signals.mem_size, op.alu_result);
        int l = lane_len(op.signals.mem_size);
        logic [31:0] v = rdata >> (8 * s);
        if (l == 1) begin
            v = v & 32'h0000_00FF;
            if (op.signals.mem_signed && v[7]) v = v | 32'hFFFF_FF00;
        end else if (l == 2) begin
            v = v & 32'h0000_FFFF;
            if (op.signals.mem_signed && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic exp_t exp_record(input pipe_EX_MEM_reg_t op, input logic [31:0] rdata);
        exp_t e;
        logic t = trap_expected(op);
        e.wb.inst     = op.inst;
        e.wb.signals  = op.signals;
        e.wb.write_id = op.write_id;
        e.wb.result   = (op.signals.mem_read && op.signals.mem_to_reg && !t)
                        ? exp_load(op, rdata) : op.alu_result;
        if (t) e.wb.signals.reg_write = 1'b0;
        e.misalign = t;
        return e;
    endfunction

    function automatic pipe_EX_MEM_reg_t mk_op(input logic rd, input logic wr, input logic rw,
                                               input mem_size_t sz, input logic sgn,
                                               input logic [31:0] alu, input logic [31:0] data,
                                               input logic [4:0] id);
        pipe_EX_MEM_reg_t op;
        op.inst               = $urandom;
        op.signals.mem_read   = rd;
        op.signals.mem_write  = wr;
        op.signals.reg_write  = rw;
        op.signals.mem_to_reg = rd;
        op.signals.mem_size   = sz;
        op.signals.mem_signed = sgn;
        op.alu_result         = alu;
        op.store_data         = data;
        op.write_id           = id;
        return op;
    endfunction

    // Scoreboard consumer: every valid MEM/WB beat must match the oldest expectation.
    always @(negedge clock) begin
        if (reset && mem_wb_valid) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", 96'(mem_wb_valid), 96'(0));
            end else begin
                mon_e = sb_q.pop_front();
                check("wb_record", 96'(mem_wb_out), 96'(mon_e.wb));
                check("wb_misalign", 96'(misalign), 96'(mon_e.misalign));
            end
        end
    end

    // Drives one op, plays the memory with `waits` extra cycles, returns just after completion.
    task automatic run_op(input string tag, input pipe_EX_MEM_reg_t op, input int waits,
                          input logic [31:0] rdata);
        int   req_cycles   = 0;
        int   stall_cycles = 0;
        int   cycles       = 0;
        bit   done         = 1'b0;
        logic trap         = trap_expected(op);
        logic access       = (op.signals.mem_read | op.signals.mem_write) & ~trap;
        sb_q.push_back(exp_record(op, rdata));
        ex_mem_in    = op;
        ex_mem_valid = 1'b1;
        dmem_ack     = 1'b0;
        while (!done && cycles < waits + 8) begin
            @(negedge clock);
            if (dmem_req) begin
                if (req_cycles == 0) begin
                    check({tag, "_addr"}, 96'(dmem_addr), 96'(op.alu_result & 32'hFFFF_FFFC));
                    check({tag, "_we"}, 96'(dmem_we), 96'(op.signals.mem_write));
                    if (op.signals.mem_write) begin
                        check({tag, "_be"}, 96'(dmem_be), 96'(exp_be(op)));
                        check({tag, "_wdata"}, 96'(dmem_wdata), 96'(exp_wdata(op)));
                    end
                end
                req_cycles++;
                if (req_cycles > waits) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end else begin
                    dmem_rdata = $urandom;
                end
            end
            #1;
            if (mem_stall) stall_cycles++;
            @(posedge clock);
            #1;
            cycles++;
            done     = access ? dmem_ack : 1'b1;
            dmem_ack = 1'b0;
        end
        check({tag, "_done"}, 96'(done), 96'(1));
        check({tag, "_wbvalid"}, 96'(mem_wb_valid), 96'(1));
        check({tag, "_reqcyc"}, 96'(req_cycles), 96'(access ? waits + 1 : 0));
        check({tag, "_stallcyc"}, 96'(stall_cycles), 96'(access ? waits + 1 : 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        pipe_EX_MEM_reg_t op;
        pipe_EX_MEM_reg_t rst_op;

        // Reset state
        #12;
        check("rst_wbvalid", 96'(mem_wb_valid), 96'(0));
        check("rst_wbout", 96'(mem_wb_out), 96'(0));
        check("rst_req", 96'(dmem_req), 96'(0));
        check("rst_misalign", 96'(misalign), 96'(0));
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Plain ALU op, one-cycle pass-through
        op = mk_op(1'b0, 1'b0, 1'b1, MEM_W, 1'b0, 32'h0000_0010, 32'h0, 5'd5);
        run_op("alu", op, 0, 32'h0);

        // SW, zero-wait ack
        op = mk_op(1'b0, 1'b1, 1'b0, MEM_W, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0);
        run_op("sw", op, 0, 32'h0);

        // LB / LBU with three wait cycles
        op = mk_op(1'b1, 1'b0, 1'b1, MEM_B, 1'b1, 32'h0000_0203, 32'h0, 5'd7);
        run_op("lb", op, 3, 32'h8012_3456);
        op = mk_op(1'b1, 1'b0, 1'b1, MEM_B, 1'b0, 32'h0000_0203, 32'h0, 5'd8);
        run_op("lbu", op, 3, 32'h8012_3456);

        // SH upper half
        op = mk_op(1'b0, 1'b1, 1'b0, MEM_H, 1'b0, 32'h0000_0302, 32'h0000_1234, 5'd0);
        run_op("sh", op, 1, 32'h0);

        // Signed half load from upper half
        op = mk_op(1'b1, 1'b0, 1'b1, MEM_H, 1'b1, 32'h0000_0312, 32'h0, 5'd9);
        run_op("lh", op, 0, 32'hC001_7FFF);

        // Misaligned word load: traps when the option is built in, else ignores low bits
        op = mk_op(1'b1, 1'b0, 1'b1, MEM_W, 1'b0, 32'h0000_0401, 32'h0, 5'd10);
        run_op("lw_mis", op, 0, 32'h1357_9BDF);

        ex_mem_valid = 1'b0;
        @(posedge clock);
        #1;

        // Back-to-back mix of ALU ops, loads and stores with random waits
        for (int i = 0; i < 24; i++) begin
            int        kind = $urandom_range(0, 2);
            mem_size_t sz   = mem_size_t'($urandom_range(0, 2));
            op = mk_op(kind == 1, kind == 2, kind != 2, sz, 1'($urandom_range(0, 1)),
                       $urandom, $urandom, 5'($urandom_range(1, 31)));
            run_op("rnd", op, $urandom_range(0, 3), $urandom);
        end
        ex_mem_valid = 1'b0;
        @(posedge clock);
        #1;

        // Reset in the middle of an access, then a late ack
        rst_op = mk_op(1'b0, 1'b1, 1'b0, MEM_W, 1'b0, 32'h0000_0500, 32'hCAFE_F00D, 5'd0);
        ex_mem_in    = rst_op;
        ex_mem_valid = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_req_before", 96'(dmem_req), 96'(1));
        #2;
        reset = 1'b0;
        #1;
        check("midrst_req", 96'(dmem_req), 96'(0));
        check("midrst_wbvalid", 96'(mem_wb_valid), 96'(0));
        ex_mem_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        dmem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            check("late_ack_req", 96'(dmem_req), 96'(0));
            check("late_ack_wbvalid", 96'(mem_wb_valid), 96'(0));
        end
        dmem_ack = 1'b0;
        @(posedge clock);
        #1;

        check("sb_drained", 96'(sb_q.size()), 96'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
